// File: rtl/truth_table_sweeper.sv
// Sequential stimulus/capture engine: sweeps every input vector of a function
// under test, captures its Y output into a truth table and compares each row.
module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 y_in,
  output logic [N_IN-1:0]      out_vec,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic                 mismatch,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err
);

  localparam int ROWS = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_ROW   = '1;
  localparam logic [N_IN-1:0] VEC_ONE    = 1;
  localparam logic [N_IN:0]   ERR_ONE    = 1;
  localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ROWS-1:0]   exp_q, exp_d;
  logic [N_IN-1:0]   out_vec_q, out_vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ROWS-1:0]   table_q, table_d;
  logic              mismatch_q, mismatch_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   first_q, first_d;
  logic [3:0]        cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      exp_q      <= '0;
      out_vec_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      first_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      out_vec_q  <= out_vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      first_q    <= first_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    out_vec_d  = out_vec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
    first_d    = first_q;
    cnt_d      = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          exp_d      = expected;
          out_vec_d  = '0;
          table_d    = '0;
          mismatch_d = 1'b0;
          err_d      = '0;
          first_d    = '0;
          cnt_d      = SETTLE_CNT;
          busy_d     = 1'b1;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          table_d[out_vec_q] = y_in;
          if (y_in != exp_q[out_vec_q]) begin
            err_d      = err_q + ERR_ONE;
            mismatch_d = 1'b1;
            if (!mismatch_q) first_d = out_vec_q;
          end
          // done is registered, so it is raised on entry to DONE to be high there
          if (out_vec_q == LAST_ROW) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            out_vec_d = out_vec_q + VEC_ONE;
            cnt_d     = SETTLE_CNT;
          end
        end
      end

      S_DONE: begin
        busy_d    = 1'b0;
        out_vec_d = '0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign out_vec   = out_vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign first_err = first_q;

endmodule
